rs_dec_syndrome_calc_p: RTL and testbench

Parametrised Reed-Solomon syndrome calculator over GF(2^8) for the CD CIRC decoder. It accepts one codeword symbol per qualified cycle and computes NSYND syndromes by Horner evaluation. It also counts erasure flags and checks codeword length. It replaces the fixed 4-syndrome front end, so the same block serves both C1 (32,28) and C2 (28,24) decoders. It feeds the Euclid stage through `o_ready` and the packed `o_synd`.

---
 rtl/rs_dec_syndrome_calc_p.sv | 118 +++++++++++
 tb/tb_rs_dec_syndrome_calc_p.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rs_dec_syndrome_calc_p.sv
// Reed-Solomon syndrome calculator over GF(2^8), one symbol per qualified cycle.
// Horner evaluation at alpha^(FCR+j), plus erasure counting and length checking.
module rs_dec_syndrome_calc_p #(
  parameter int          NSYMB = 32,
  parameter int          NSYND = 4,
  parameter int          FCR   = 0,
  parameter logic [7:0]  POLY  = 8'h1D
) (
  input  logic                         i_clk,
  input  logic                         i_resb,
  input  logic                         i_data_sync,
  input  logic                         i_frame_sync,
  input  logic [7:0]                   i_data,
  input  logic                         i_erasure,
  output logic [8*NSYND-1:0]           o_synd,
  output logic                         o_zero,
  output logic [$clog2(NSYMB+1)-1:0]   o_eras_cnt,
  output logic                         o_eras_ovf,
  output logic                         o_ready,
  output logic                         o_len_err
);

  localparam int CW = $clog2(NSYMB + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACC  = 1'b1;

  logic [0:0]           state;
  logic [8*NSYND-1:0]   acc;
  logic [8*NSYND-1:0]   nxt;
  logic [CW-1:0]        sym_cnt;
  logic [CW-1:0]        eras_cnt;
  logic [CW-1:0]        eras_inc;
  logic [CW-1:0]        eras_first;
  logic                 last;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? POLY : 8'h00);
  endfunction

  // Constant multiply by alpha^n as a chain of n xtime steps.
  function automatic logic [7:0] mul_pow(input logic [7:0] x,
                                         input int n);
    logic [7:0] y;
    y = x;
    for (int k = 0; k < n; k++) y = xtime(y);
    return y;
  endfunction

  for (genvar j = 0; j < NSYND; j++) begin : g_horner
    assign nxt[8*j +: 8] =
      mul_pow(acc[8*j +: 8], FCR + j) ^ i_data;
  end

  assign last = (sym_cnt == CW'(NSYMB - 1));

  assign eras_inc =
    (i_erasure && (eras_cnt != CW'(NSYMB)))
      ? eras_cnt + 1'b1
      : eras_cnt;

  assign eras_first = {{(CW-1){1'b0}}, i_erasure};

  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb) begin
      state      <= IDLE;
      acc        <= '0;
      sym_cnt    <= '0;
      eras_cnt   <= '0;
      o_synd     <= '0;
      o_zero     <= 1'b0;
      o_eras_cnt <= '0;
      o_eras_ovf <= 1'b0;
      o_ready    <= 1'b0;
      o_len_err  <= 1'b0;
    end else begin
      o_ready   <= 1'b0;
      o_len_err <= 1'b0;
      if (i_data_sync) begin
        unique case (state)
          IDLE: begin
            if (i_frame_sync) begin
              acc      <= {NSYND{i_data}};
              sym_cnt  <= CW'(1);
              eras_cnt <= eras_first;
              state    <= ACC;
            end
          end
          ACC: begin
            if (i_frame_sync && !last) begin
              // Restart on an early sync; outputs keep the last good word.
              acc       <= {NSYND{i_data}};
              sym_cnt   <= CW'(1);
              eras_cnt  <= eras_first;
              o_len_err <= 1'b1;
            end else if (last) begin
              acc        <= nxt;
              sym_cnt    <= '0;
              eras_cnt   <= '0;
              o_synd     <= nxt;
              o_zero     <= ~|nxt;
              o_eras_cnt <= eras_inc;
              o_eras_ovf <= (eras_inc > CW'(NSYND));
              o_ready    <= 1'b1;
              state      <= IDLE;
            end else begin
              acc      <= nxt;
              sym_cnt  <= sym_cnt + 1'b1;
              eras_cnt <= eras_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rs_dec_syndrome_calc_p.sv
// Directed bench for rs_dec_syndrome_calc_p: default (32,4) and (28,4) instances.
// Expected syndromes are hand-computed powers of alpha over x^8+x^4+x^3+x^2+1.
module tb_rs_dec_syndrome_calc_p;

  logic clk;
  logic rst_n;

  logic        a_sync, a_fs, a_eras;
  logic [7:0]  a_data;
  logic [31:0] a_synd;
  logic        a_zero, a_ovf, a_ready, a_len;
  logic [5:0]  a_ecnt;

  logic        b_sync, b_fs, b_eras;
  logic [7:0]  b_data;
  logic [31:0] b_synd;
  logic        b_zero, b_ovf, b_ready, b_len;
  logic [4:0]  b_ecnt;

  int passed = 0;
  int total  = 0;

  int cyc = 0;
  int ra = 0, la = 0, rb = 0, lb = 0;
  int tb_prev = 0, tb_last = 0;

  rs_dec_syndrome_calc_p dut_a (
    .i_clk(clk), .i_resb(rst_n),
    .i_data_sync(a_sync), .i_frame_sync(a_fs),
    .i_data(a_data), .i_erasure(a_eras),
    .o_synd(a_synd), .o_zero(a_zero),
    .o_eras_cnt(a_ecnt), .o_eras_ovf(a_ovf),
    .o_ready(a_ready), .o_len_err(a_len)
  );

  rs_dec_syndrome_calc_p #(.NSYMB(28), .NSYND(4)) dut_b (
    .i_clk(clk), .i_resb(rst_n),
    .i_data_sync(b_sync), .i_frame_sync(b_fs),
    .i_data(b_data), .i_erasure(b_eras),
    .o_synd(b_synd), .o_zero(b_zero),
    .o_eras_cnt(b_ecnt), .o_eras_ovf(b_ovf),
    .o_ready(b_ready), .o_len_err(b_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (a_ready) ra = ra + 1;
    if (a_len)   la = la + 1;
    if (b_len)   lb = lb + 1;
    if (b_ready) begin
      rb = rb + 1;
      tb_prev = tb_last;
      tb_last = cyc;
    end
  end

  task automatic idle_cyc();
    a_sync = 1'b0; a_fs = 1'b1; a_data = 8'hFF; a_eras = 1'b1;
    b_sync = 1'b0; b_fs = 1'b1; b_data = 8'hFF; b_eras = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_sym(input bit sel, input logic fs,
                          input logic [7:0] d, input logic e);
    if (!sel) begin
      a_sync = 1'b1; a_fs = fs; a_data = d; a_eras = e;
    end else begin
      b_sync = 1'b1; b_fs = fs; b_data = d; b_eras = e;
    end
    @(posedge clk); #1;
  endtask

  task automatic frame(input bit sel, input int n,
                       input int p1, input logic [7:0] v1,
                       input int p2, input logic [7:0] v2,
                       input logic [31:0] emask, input bit gaps,
                       input bit last_fs);
    logic [7:0] d;
    for (int k = 1; k <= n; k++) begin
      if (gaps && (k % 4 == 0)) idle_cyc();
      d = 8'h00;
      if (k == p1) d = v1;
      if (k == p2) d = v2;
      send_sym(sel, (k == 1) || (last_fs && k == n), d, emask[k-1]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_cyc();
    idle_cyc();
    total++; if (a_synd !== 32'h0) $display("FAIL rst_synd: got %h want %h", a_synd, 32'h0); else passed++;
    total++; if (a_zero !== 1'b0) $display("FAIL rst_zero: got %b want 0", a_zero); else passed++;
    total++; if (a_ecnt !== 6'd0) $display("FAIL rst_ecnt: got %0d want 0", a_ecnt); else passed++;
    total++; if ({a_ovf, a_ready, a_len} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {a_ovf, a_ready, a_len}); else passed++;
    total++; if (b_synd !== 32'h0) $display("FAIL rst_synd_b: got %h want %h", b_synd, 32'h0); else passed++;
    rst_n = 1'b1;
    idle_cyc();
  endtask

  task automatic test_all_zero();
    int r0;
    r0 = ra;
    frame(0, 32, 0, 8'h00, 0, 8'h00, 32'h0, 0, 0);
    total++; if (a_ready !== 1'b1) $display("FAIL zero_ready: got %b want 1", a_ready); else passed++;
    total++; if (a_synd !== 32'h0) $display("FAIL zero_synd: got %h want %h", a_synd, 32'h0); else passed++;
    total++; if (a_zero !== 1'b1) $display("FAIL zero_flag: got %b want 1", a_zero); else passed++;
    total++; if (a_ecnt !== 6'd0) $display("FAIL zero_ecnt: got %0d want 0", a_ecnt); else passed++;
    idle_cyc();
    total++; if (a_ready !== 1'b0) $display("FAIL zero_ready_fall: got %b want 0", a_ready); else passed++;
    total++; if (ra - r0 !== 1) $display("FAIL zero_ready_count: got %0d want 1", ra - r0); else passed++;
  endtask

  task automatic test_single_error();
    frame(0, 32, 31, 8'h01, 0, 8'h00, 32'h0, 0, 0);
    total++; if (a_synd !== 32'h08040201) $display("FAIL err31_synd: got %h want %h", a_synd, 32'h08040201); else passed++;
    total++; if (a_zero !== 1'b0) $display("FAIL err31_zero: got %b want 0", a_zero); else passed++;
    idle_cyc();
    frame(0, 32, 32, 8'h01, 0, 8'h00, 32'h0, 0, 0);
    total++; if (a_synd !== 32'h01010101) $display("FAIL err32_synd: got %h want %h", a_synd, 32'h01010101); else passed++;
    idle_cyc();
  endtask

  task automatic test_early_sync();
    int r0, l0;
    r0 = ra; l0 = la;
    for (int k = 1; k <= 9; k++) send_sym(0, k == 1, 8'h5A, 1'b0);
    send_sym(0, 1'b1, 8'h00, 1'b0);
    total++; if (a_len !== 1'b1) $display("FAIL early_len: got %b want 1", a_len); else passed++;
    total++; if (a_ready !== 1'b0) $display("FAIL early_noready: got %b want 0", a_ready); else passed++;
    total++; if (a_synd !== 32'h01010101) $display("FAIL early_hold: got %h want %h", a_synd, 32'h01010101); else passed++;
    for (int k = 2; k <= 32; k++) send_sym(0, 1'b0, 8'h00, 1'b0);
    total++; if (a_ready !== 1'b1) $display("FAIL early_ready: got %b want 1", a_ready); else passed++;
    total++; if (a_zero !== 1'b1) $display("FAIL early_zero: got %b want 1", a_zero); else passed++;
    idle_cyc();
    total++; if (la - l0 !== 1) $display("FAIL early_len_count: got %0d want 1", la - l0); else passed++;
    total++; if (ra - r0 !== 1) $display("FAIL early_ready_count: got %0d want 1", ra - r0); else passed++;
  endtask

  task automatic test_erasures_gaps();
    frame(0, 32, 24, 8'h01, 0, 8'h00, 32'h20102084, 1, 0);
    total++; if (a_synd !== 32'h8F4C1D01) $display("FAIL eras_synd: got %h want %h", a_synd, 32'h8F4C1D01); else passed++;
    total++; if (a_ecnt !== 6'd5) $display("FAIL eras_cnt: got %0d want 5", a_ecnt); else passed++;
    total++; if (a_ovf !== 1'b1) $display("FAIL eras_ovf: got %b want 1", a_ovf); else passed++;
    total++; if (a_zero !== 1'b0) $display("FAIL eras_zero: got %b want 0", a_zero); else passed++;
    idle_cyc();
  endtask

  task automatic test_back_to_back();
    int r0, l0;
    r0 = rb; l0 = lb;
    frame(1, 28, 27, 8'h03, 28, 8'h05, 32'h0, 0, 1);
    total++; if (b_ready !== 1'b1) $display("FAIL b2b_ready1: got %b want 1", b_ready); else passed++;
    total++; if (b_synd !== 32'h1D090306) $display("FAIL b2b_synd1: got %h want %h", b_synd, 32'h1D090306); else passed++;
    for (int k = 1; k <= 28; k++) begin
      send_sym(1, k == 1, (k == 26) ? 8'h01 : 8'h00, 1'b0);
      if (k == 10) begin
        total++; if (b_synd !== 32'h1D090306) $display("FAIL b2b_hold: got %h want %h", b_synd, 32'h1D090306); else passed++;
      end
    end
    total++; if (b_synd !== 32'h40100401) $display("FAIL b2b_synd2: got %h want %h", b_synd, 32'h40100401); else passed++;
    idle_cyc();
    total++; if (rb - r0 !== 2) $display("FAIL b2b_ready_count: got %0d want 2", rb - r0); else passed++;
    total++; if (tb_last - tb_prev !== 28) $display("FAIL b2b_spacing: got %0d want 28", tb_last - tb_prev); else passed++;
    total++; if (lb - l0 !== 0) $display("FAIL b2b_no_len: got %0d want 0", lb - l0); else passed++;
  endtask

  task automatic test_reset_mid();
    int r0, l0;
    for (int k = 1; k <= 14; k++) send_sym(0, k == 1, 8'h33, 1'b1);
    r0 = ra; l0 = la;
    rst_n = 1'b0;
    #1;
    total++; if (a_synd !== 32'h0) $display("FAIL rmid_synd: got %h want %h", a_synd, 32'h0); else passed++;
    total++; if ({a_ecnt, a_ovf, a_zero} !== 8'h00) $display("FAIL rmid_outs: got %h want 00", {a_ecnt, a_ovf, a_zero}); else passed++;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 16; k <= 40; k++) send_sym(0, 1'b0, 8'h33, 1'b1);
    idle_cyc();
    total++; if (ra - r0 !== 0) $display("FAIL rmid_no_ready: got %0d want 0", ra - r0); else passed++;
    total++; if (la - l0 !== 0) $display("FAIL rmid_no_len: got %0d want 0", la - l0); else passed++;
    total++; if (a_synd !== 32'h0) $display("FAIL rmid_ignored: got %h want %h", a_synd, 32'h0); else passed++;
    frame(0, 32, 32, 8'h01, 0, 8'h00, 32'h0, 0, 0);
    total++; if (a_synd !== 32'h01010101) $display("FAIL rmid_recover: got %h want %h", a_synd, 32'h01010101); else passed++;
    idle_cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    a_sync = 1'b0; a_fs = 1'b0; a_data = 8'h00; a_eras = 1'b0;
    b_sync = 1'b0; b_fs = 1'b0; b_data = 8'h00; b_eras = 1'b0;
    test_reset();
    test_all_zero();
    test_single_error();
    test_early_sync();
    test_erasures_gaps();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
